// File: rtl/idu_pkg.sv
// Shared constants for the decode stage: RV32I opcodes, one-hot type positions
// and the immediate extraction helper.
package idu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int T_I     = 0;
    localparam int T_L     = 1;
    localparam int T_S     = 2;
    localparam int T_R     = 3;
    localparam int T_JAL   = 4;
    localparam int T_JALR  = 5;
    localparam int T_LUI   = 6;
    localparam int T_AUIPC = 7;
    localparam int T_B     = 8;
    localparam int NTYPE   = 9;

    typedef logic [NTYPE-1:0] itype_t;

    // 32-bit immediate; R-type and illegal encodings yield zero
    function automatic logic [31:0] imm32(input logic [31:0] ins, input itype_t t);
        logic [31:0] r;
        r = '0;
        if (t[T_I] | t[T_L] | t[T_JALR]) r = {{20{ins[31]}}, ins[31:20]};
        else if (t[T_S])                 r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        else if (t[T_B])                 r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        else if (t[T_LUI] | t[T_AUIPC])  r = {ins[31:12], 12'b0};
        else if (t[T_JAL])               r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/idu_pipe_if.sv
// IF/EX/WB-facing signal bundle of the decode stage; slave is the stage itself.
interface idu_pipe_if #(
    parameter int XLEN = idu_pkg::XLEN_DEF,
    parameter int NREG = idu_pkg::NREG_DEF
);
    localparam int RAW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            wb_en;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc, out_pc_add_imme, out_imme, out_rs1_data, out_rs2_data;
    logic [RAW-1:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]      out_func3;
    logic            out_func7;
    logic [8:0]      out_type;
    logic            out_wr_reg;

    modport master (
        output in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_add_imme, out_imme, out_rs1_data,
               out_rs2_data, out_rs1, out_rs2, out_rd, out_func3, out_func7, out_type, out_wr_reg
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_pc_add_imme, out_imme, out_rs1_data,
               out_rs2_data, out_rs1, out_rs2, out_rd, out_func3, out_func7, out_type, out_wr_reg
    );

endinterface

// File: rtl/idu_scoreboard.sv
// Pending-write tracker for in-flight destinations plus a 3-way hazard query
// that folds in the output-register match and same-cycle writeback bypass.
module idu_scoreboard
    import idu_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en_i,
    input  logic [RAW-1:0]      set_idx_i,
    input  logic                clr_en_i,
    input  logic [RAW-1:0]      clr_idx_i,
    input  logic                held_vld_i,
    input  logic [RAW-1:0]      held_rd_i,
    input  logic [2:0][RAW-1:0] q_idx_i,
    output logic [2:0]          pend_o
);

    logic [NREG-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en_i) sb_d[clr_idx_i] = 1'b0;
        if (set_en_i) sb_d[set_idx_i] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    // A writeback retires the scoreboard entry but never the bundle still held
    // in the output register, which has not yet been dispatched.
    for (genvar k = 0; k < 3; k++) begin : g_q
        logic held_m, wb_m;
        assign held_m    = held_vld_i && (held_rd_i == q_idx_i[k]);
        assign wb_m      = clr_en_i && (clr_idx_i == q_idx_i[k]);
        assign pend_o[k] = (q_idx_i[k] != '0) && (held_m || (sb_q[q_idx_i[k]] && !wb_m));
    end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: RV32I field decode, write-through register file, hazard stall,
// and a registered valid/ready output bundle with branch flush.
module idu_pipe
    import idu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int RAW  = $clog2(NREG)
) (
    input logic      clk,
    input logic      rst_n,
    idu_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc, pai, imm, d1, d2;
        logic [RAW-1:0]  rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
        itype_t          typ;
        logic            wr;
    } bundle_t;

    itype_t          typ;
    logic            uses_rs1, uses_rs2, writes_rd, hazard, in_ready, in_fire, out_fire;
    logic [RAW-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0] imm, rs1_data, rs2_data;
    logic [2:0]      pend;
    logic [NREG-1:0][XLEN-1:0] rf_q;
    bundle_t         out_q, out_d;
    logic            vld_q, vld_d;

    always_comb begin
        typ = '0;
        case (bus.in_instr[6:0])
            OP_IMM:   typ[T_I]     = 1'b1;
            OP_LOAD:  typ[T_L]     = 1'b1;
            OP_STORE: typ[T_S]     = 1'b1;
            OP_REG:   typ[T_R]     = 1'b1;
            OP_BR:    typ[T_B]     = 1'b1;
            OP_JAL:   typ[T_JAL]   = 1'b1;
            OP_JALR:  typ[T_JALR]  = 1'b1;
            OP_LUI:   typ[T_LUI]   = 1'b1;
            OP_AUIPC: typ[T_AUIPC] = 1'b1;
            default:  ;
        endcase
    end

    assign rs1       = RAW'(bus.in_instr[19:15]);
    assign rs2       = RAW'(bus.in_instr[24:20]);
    assign rd        = RAW'(bus.in_instr[11:7]);
    assign uses_rs1  = typ[T_I] | typ[T_L] | typ[T_S] | typ[T_R] | typ[T_B] | typ[T_JALR];
    assign uses_rs2  = typ[T_S] | typ[T_R] | typ[T_B];
    assign writes_rd = (typ[T_I] | typ[T_L] | typ[T_R] | typ[T_JAL] | typ[T_JALR] |
                        typ[T_LUI] | typ[T_AUIPC]) && (rd != '0);
    assign imm       = XLEN'($signed(imm32(bus.in_instr, typ)));

    // Write-through read: a same-cycle writeback is visible to the decode
    assign rs1_data = (rs1 == '0) ? '0 :
                      (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1];
    assign rs2_data = (rs2 == '0) ? '0 :
                      (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             rf_q <= '0;
        else if (bus.wb_en && bus.wb_rd != '0) rf_q[bus.wb_rd] <= bus.wb_data;
    end

    idu_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (out_fire && out_q.wr),
        .set_idx_i  (out_q.rd),
        .clr_en_i   (bus.wb_en),
        .clr_idx_i  (bus.wb_rd),
        .held_vld_i (vld_q && out_q.wr),
        .held_rd_i  (out_q.rd),
        .q_idx_i    ({rd, rs2, rs1}),
        .pend_o     (pend)
    );

    assign hazard   = (uses_rs1 && pend[0]) || (uses_rs2 && pend[1]) || (writes_rd && pend[2]);
    assign in_ready = !bus.flush && !hazard && (!vld_q || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    // A flushed bundle never counts as dispatched
    assign out_fire = vld_q && bus.out_ready && !bus.flush;

    always_comb begin
        vld_d = vld_q;
        out_d = out_q;
        if (bus.flush) begin
            vld_d = 1'b0;
        end else if (in_fire) begin
            vld_d     = 1'b1;
            out_d.pc  = bus.in_pc;
            out_d.pai = bus.in_pc + imm;
            out_d.imm = imm;
            out_d.d1  = rs1_data;
            out_d.d2  = rs2_data;
            out_d.rs1 = rs1;
            out_d.rs2 = rs2;
            out_d.rd  = rd;
            out_d.f3  = bus.in_instr[14:12];
            out_d.f7  = bus.in_instr[30];
            out_d.typ = typ;
            out_d.wr  = writes_rd;
        end else if (out_fire) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            out_q <= '0;
        end else begin
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = vld_q;
    assign bus.out_pc          = out_q.pc;
    assign bus.out_pc_add_imme = out_q.pai;
    assign bus.out_imme        = out_q.imm;
    assign bus.out_rs1_data    = out_q.d1;
    assign bus.out_rs2_data    = out_q.d2;
    assign bus.out_rs1         = out_q.rs1;
    assign bus.out_rs2         = out_q.rs2;
    assign bus.out_rd          = out_q.rd;
    assign bus.out_func3       = out_q.f3;
    assign bus.out_func7       = out_q.f7;
    assign bus.out_type        = out_q.typ;
    assign bus.out_wr_reg      = out_q.wr;

endmodule
